// File: rtl/mul6_pkg.sv
// Shared definitions for the 6x6 sequential multiply path: widths and the
// controller state encoding.
package mul6_pkg;

    localparam int MUL_WIDTH = 6;
    localparam int CNT_W     = $clog2(MUL_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateE;

endpackage

// File: rtl/mul6_seq_ctrl_if.sv
// Start/busy/done handshake plus operands and product between the muldiv top
// level (master) and the multiply sequencer (slave).
interface mul6_seq_ctrl_if
    import mul6_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/fa.sv
// Single-bit full adder cell; y is the carry-in and c the carry-out.
module fa (
    input  logic a,
    input  logic b,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ y;
    assign c = (a & b) | (y & (a ^ b));
endmodule

// File: rtl/fa_row.sv
// N-bit ripple-carry adder row built from chained fa cells.
module fa_row #(
    parameter int N = 6
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);
    logic [N:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[N];

    for (genvar i = 0; i < N; i++) begin : gBit
        fa uFa (
            .a (x[i]),
            .b (y[i]),
            .y (carry[i]),
            .s (s[i]),
            .c (carry[i+1])
        );
    end
endmodule

// File: rtl/mul6_seq_ctrl.sv
// Shift-add multiply sequencer: one adder row reused over WIDTH iterations,
// with the start/busy/done handshake toward the muldiv top level.
module mul6_seq_ctrl
    import mul6_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mul6_seq_ctrl_if.slave bus
);
    localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    stateE               stateQ;
    stateE               stateD;
    logic                accept;

    logic [WIDTH-1:0]    mReg;
    logic [2*WIDTH-1:0]  acc;
    logic [CntW-1:0]     cnt;
    logic [2*WIDTH-1:0]  pQ;
    logic                busyQ;
    logic                doneQ;

    logic [WIDTH-1:0]    addend;
    logic [WIDTH-1:0]    sum;
    logic                carryOut;
    logic [2*WIDTH-1:0]  accShifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // start is only honoured in IDLE or DONE; RUN always completes its count
    always_comb begin
        stateD = stateQ;
        accept = 1'b0;
        case (stateQ)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    stateD = RUN;
                end
            end
            RUN: begin
                if (cnt == LastCnt) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                accept = bus.start;
                stateD = bus.start ? RUN : IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    assign addend = acc[0] ? mReg : '0;

    fa_row #(.N(WIDTH)) uRow (
        .x    (acc[2*WIDTH-1:WIDTH]),
        .y    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (carryOut)
    );

    // carry re-enters at the MSB, so the full product fits without loss
    assign accShifted = {carryOut, sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mReg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            pQ    <= '0;
            busyQ <= 1'b0;
            doneQ <= 1'b0;
        end else begin
            busyQ <= (stateD == RUN);
            doneQ <= (stateD == DONE);
            if (accept) begin
                mReg <= bus.a;
                acc  <= {{WIDTH{1'b0}}, bus.b};
                cnt  <= '0;
                pQ   <= '0;
            end else if (stateQ == RUN) begin
                acc <= accShifted;
                cnt <= cnt + CntW'(1);
                if (stateD == DONE) begin
                    pQ <= accShifted;
                end
            end
        end
    end

    assign bus.busy = busyQ;
    assign bus.done = doneQ;
    assign bus.p    = pQ;
endmodule

// File: tb/tb_mul6_seq_ctrl.sv
// Directed bench for mul6_seq_ctrl: vector table plus hand-written multi-cycle
// sequences (ignored start, back-to-back, reset mid-operation).
module tb_mul6_seq_ctrl;
    import mul6_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mul6_seq_ctrl_if #(.WIDTH(6)) bus ();

    mul6_seq_ctrl #(.WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] expP;
        string       name;
    } vecT;

    vecT vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Called at a falling edge; start is sampled at the next rising edge (t).
    task automatic runOp(input logic [5:0] va, input logic [5:0] vb,
                         input logic [11:0] expP, input string nm);
        int          busyCnt;
        int          doneCnt;
        int          doneAt;
        logic [11:0] pAt;
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = 0;
        pAt     = '0;
        bus.start = 1'b1;
        bus.a     = va;
        bus.b     = vb;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 6'($urandom);
        bus.b     = 6'($urandom);
        for (int k = 1; k <= 9; k++) begin
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = k;
                    pAt    = bus.p;
                end
            end
            @(negedge clk);
        end
        chk({nm, " doneAt"}, doneAt, 7);
        chk({nm, " busyCycles"}, busyCnt, 6);
        chk({nm, " donePulses"}, doneCnt, 1);
        chk({nm, " p"}, pAt, expP);
        chk({nm, " pHeld"}, bus.p, expP);
    endtask

    initial begin
        int          busyCnt;
        int          doneCnt;
        int          doneAt;
        int          doneAt2;
        logic [11:0] pAt;
        logic [11:0] pAt2;

        vecs[0] = '{6'd63, 6'd63, 12'd3969, "max"};
        vecs[1] = '{6'd0,  6'd45, 12'd0,    "zeroA"};
        vecs[2] = '{6'd1,  6'd63, 12'd63,   "oneA"};
        vecs[3] = '{6'd45, 6'd27, 12'd1215, "typical"};
        vecs[4] = '{6'd63, 6'd1,  12'd63,   "oneB"};
        vecs[5] = '{6'd42, 6'd0,  12'd0,    "zeroB"};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset busy", bus.busy, 0);
            chk("reset done", bus.done, 0);
            chk("reset p", bus.p, 0);
        end

        for (int i = 0; i < 6; i++) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].expP, vecs[i].name);
        end

        // Hold after the typical product with no start: p stays, FSM idles
        runOp(6'd45, 6'd27, 12'd1215, "typicalHold");
        repeat (4) @(negedge clk);
        chk("hold p", bus.p, 1215);
        chk("hold busy", bus.busy, 0);
        chk("hold state", 32'(dut.stateQ), 32'(IDLE));

        // start during RUN must not re-latch operands or restart the count
        busyCnt = 0; doneCnt = 0; doneAt = 0; pAt = '0;
        bus.start = 1'b1; bus.a = 6'd5; bus.b = 6'd7;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = k;
                    pAt    = bus.p;
                end
            end
            bus.start = (k == 3);
            if (k == 3) begin
                bus.a = 6'd63;
                bus.b = 6'd63;
            end
            @(negedge clk);
        end
        chk("ignored doneAt", doneAt, 7);
        chk("ignored busyCycles", busyCnt, 6);
        chk("ignored donePulses", doneCnt, 1);
        chk("ignored p", pAt, 35);

        // Back-to-back: second start lands in the first DONE cycle
        busyCnt = 0; doneCnt = 0; doneAt = 0; doneAt2 = 0; pAt = '0; pAt2 = '0;
        bus.start = 1'b1; bus.a = 6'd12; bus.b = 6'd10;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneCnt++;
                if (doneAt == 0) begin
                    doneAt = k;
                    pAt    = bus.p;
                end else if (doneAt2 == 0) begin
                    doneAt2 = k;
                    pAt2    = bus.p;
                end
            end
            if (k <= 13 && k != 7) begin
                chk("b2b busyHigh", bus.busy, 1);
            end
            bus.start = (k == 7);
            if (k == 7) begin
                bus.a = 6'd9;
                bus.b = 6'd9;
            end
            @(negedge clk);
        end
        chk("b2b doneAt1", doneAt, 7);
        chk("b2b p1", pAt, 120);
        chk("b2b doneAt2", doneAt2, 14);
        chk("b2b p2", pAt2, 81);
        chk("b2b donePulses", doneCnt, 2);
        chk("b2b busyCycles", busyCnt, 12);

        // Reset in the middle of RUN: abort silently, then resume cleanly
        doneCnt = 0; busyCnt = 0;
        bus.start = 1'b1; bus.a = 6'd63; bus.b = 6'd63;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                chk("rstMid busy", bus.busy, 0);
                chk("rstMid done", bus.done, 0);
                chk("rstMid p", bus.p, 0);
                rst = 1'b0;
            end
            if (k >= 5) begin
                if (bus.done) doneCnt++;
                if (bus.busy) busyCnt++;
            end
            if (k == 4) rst = 1'b1;
            @(negedge clk);
        end
        chk("rstMid noDone", doneCnt, 0);
        chk("rstMid noBusy", busyCnt, 0);
        runOp(6'd2, 6'd3, 12'd6, "afterReset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
